// File: rtl/regfile_mp_pkg.sv
// Shared types and defaults for the multi-port register file.
// Imported by the top level and by the read-port slice.
package regfile_mp_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;

   localparam logic RST_ENABLE  = 1'b1;
   localparam logic READ_ENABLE = 1'b1;

   typedef enum logic {
      RF_ST_CLEAR = 1'b0,
      RF_ST_RUN   = 1'b1
   } rfState_e;

endpackage

// File: rtl/regfile_mp_rd_port.sv
// One read port: zero / writeback-bypass / array priority mux,
// plus busy gating that a same-cycle writeback resolves.
module regfile_rd_port
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              ready_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] waddr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] waddr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   input  logic [DATA_W-1:0] arrData_i,
   input  logic              busy_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rbusy_o
);

   logic hit0;
   logic hit1;

   always_comb begin
      hit0    = we0_i && (waddr0_i == raddr_i);
      hit1    = we1_i && (waddr1_i == raddr_i);
      rdata_o = '0;
      rbusy_o = 1'b0;
      if (ready_i && (re_i == READ_ENABLE) && (raddr_i != '0)) begin
         // Lane 1 is the younger writeback, so it shadows lane 0.
         if (hit1) begin
            rdata_o = wdata1_i;
         end else if (hit0) begin
            rdata_o = wdata0_i;
         end else begin
            rdata_o = arrData_i;
         end
         rbusy_o = busy_i && !(hit0 || hit1);
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Register file with NUM_RD read ports, two prioritised write lanes,
// a busy scoreboard and an optional post-reset clear sweep.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int NUM_RD         = DEF_NUM_RD,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     we0_i,
   input  logic [ADDR_W-1:0]        waddr0_i,
   input  logic [DATA_W-1:0]        wdata0_i,
   input  logic                     we1_i,
   input  logic [ADDR_W-1:0]        waddr1_i,
   input  logic [DATA_W-1:0]        wdata1_i,
   input  logic [NUM_RD-1:0]        re_i,
   input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
   output logic [NUM_RD*DATA_W-1:0] rdata_o,
   output logic [NUM_RD-1:0]        rbusy_o,
   input  logic                     set_busy_i,
   input  logic [ADDR_W-1:0]        set_busy_addr_i,
   output logic                     ready_o
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam rfState_e RST_STATE = (CLEAR_ON_RESET != 0) ? RF_ST_CLEAR : RF_ST_RUN;

   rfState_e          state_q, state_d;
   logic [ADDR_W-1:0] clrPtr_q, clrPtr_d;
   logic              ready_q, ready_d;
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [DATA_W-1:0] regs_q [DEPTH];

   logic wr0;
   logic wr1;

   assign wr0     = we0_i && (waddr0_i != '0);
   assign wr1     = we1_i && (waddr1_i != '0);
   assign ready_o = ready_q;

   always_comb begin
      state_d  = state_q;
      clrPtr_d = clrPtr_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      unique case (state_q)
         RF_ST_CLEAR: begin
            clrPtr_d = clrPtr_q + ADDR_W'(1);
            if (&clrPtr_q) begin
               state_d = RF_ST_RUN;
               ready_d = 1'b1;
            end
         end
         RF_ST_RUN: begin
            ready_d = 1'b1;
            if (wr0) busy_d[waddr0_i] = 1'b0;
            if (wr1) busy_d[waddr1_i] = 1'b0;
            // A new issue belongs to a younger producer than any retiring write.
            if (set_busy_i) busy_d[set_busy_addr_i] = 1'b1;
         end
      endcase
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i == RST_ENABLE) begin
         state_q  <= RST_STATE;
         clrPtr_q <= ADDR_W'(1);
         ready_q  <= 1'b0;
         busy_q   <= '0;
      end else begin
         state_q  <= state_d;
         clrPtr_q <= clrPtr_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   // The array itself is never reset so CLEAR_ON_RESET=0 keeps its contents.
   always_ff @(posedge clk_i) begin
      regs_q[0] <= '0;
      if (rst_i != RST_ENABLE) begin
         if (state_q == RF_ST_CLEAR) begin
            regs_q[clrPtr_q] <= '0;
         end else begin
            if (wr0) regs_q[waddr0_i] <= wdata0_i;
            if (wr1) regs_q[waddr1_i] <= wdata1_i;
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_rd_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_rd (
         .ready_i   (ready_q),
         .re_i      (re_i[i]),
         .raddr_i   (raddr_i[i*ADDR_W +: ADDR_W]),
         .we0_i     (we0_i),
         .waddr0_i  (waddr0_i),
         .wdata0_i  (wdata0_i),
         .we1_i     (we1_i),
         .waddr1_i  (waddr1_i),
         .wdata1_i  (wdata1_i),
         .arrData_i (regs_q[raddr_i[i*ADDR_W +: ADDR_W]]),
         .busy_i    (busy_q[raddr_i[i*ADDR_W +: ADDR_W]]),
         .rdata_o   (rdata_o[i*DATA_W +: DATA_W]),
         .rbusy_o   (rbusy_o[i])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a 4-read-port file with clear sweep, and a 1-read-port
// file without it sharing the write/issue inputs.
module tb_regfile_mp;

   logic         clk;
   logic         rst;
   logic         we0;
   logic [4:0]   waddr0;
   logic [31:0]  wdata0;
   logic         we1;
   logic [4:0]   waddr1;
   logic [31:0]  wdata1;
   logic [3:0]   re;
   logic [19:0]  raddr;
   logic [127:0] rdata;
   logic [3:0]   rbusy;
   logic         setBusy;
   logic [4:0]   setBusyAddr;
   logic         ready;

   logic         ncRst;
   logic [0:0]   ncRe;
   logic [4:0]   ncRaddr;
   logic [31:0]  ncRdata;
   logic [0:0]   ncRbusy;
   logic         ncReady;

   int checks = 0;
   int errors = 0;
   int cycles;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .CLEAR_ON_RESET(1)) dut (
      .clk_i(clk), .rst_i(rst),
      .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
      .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
      .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
      .set_busy_i(setBusy), .set_busy_addr_i(setBusyAddr), .ready_o(ready)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .CLEAR_ON_RESET(0)) dutNc (
      .clk_i(clk), .rst_i(ncRst),
      .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
      .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
      .re_i(ncRe), .raddr_i(ncRaddr), .rdata_o(ncRdata), .rbusy_o(ncRbusy),
      .set_busy_i(setBusy), .set_busy_addr_i(setBusyAddr), .ready_o(ncReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                                input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                                input logic sb, input logic [4:0] sba);
      we0 = w0e; waddr0 = w0a; wdata0 = w0d;
      we1 = w1e; waddr1 = w1a; wdata1 = w1d;
      setBusy = sb; setBusyAddr = sba;
   endtask

   task automatic idleWrites();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
   endtask

   task automatic setRaddr(input int port, input logic [4:0] a);
      raddr[port*5 +: 5] = a;
   endtask

   function automatic logic [31:0] rd(input int port);
      return rdata[port*32 +: 32];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until ready rises; during the first 20 edges lane 0 writes r3
   // and r6 is issued, both of which the sweep must ignore.
   task automatic waitReady(input logic pokeDuringSweep, output int n);
      n = 0;
      if (pokeDuringSweep)
         applyStimulus(1'b1, 5'd3, 32'hAAAA5555, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6);
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 20) idleWrites();
         if (k == 30) checkOutput("readyEarly", {31'b0, ready}, 32'd0);
         if (ready) begin
            n = k;
            break;
         end
      end
      idleWrites();
   endtask

   initial begin
      rst = 1'b1; ncRst = 1'b1;
      re = 4'b0; raddr = '0;
      ncRe = 1'b1; ncRaddr = 5'd4;
      idleWrites();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstReady", {31'b0, ready}, 32'd0);
      checkOutput("ncRstReady", {31'b0, ncReady}, 32'd0);
      re = 4'b1111;
      #1;
      checkOutput("rstRdata", rdata[31:0] | rdata[63:32], 32'd0);
      checkOutput("rstRbusy", {28'b0, rbusy}, 32'd0);

      rst = 1'b0;
      waitReady(1'b1, cycles);
      checkOutput("sweepLen", cycles, 32'd31);

      re = 4'b0001;
      for (int a = 0; a < 32; a++) begin
         setRaddr(0, 5'(a));
         #1;
         checkOutput($sformatf("sweepRd%0d", a), rd(0), 32'd0);
      end
      setRaddr(0, 5'd6);
      #1;
      checkOutput("sweepBusyIgnored", {28'b0, rbusy}, 32'd0);

      // Both lanes hit r7: lane 1 must win in bypass and in the array.
      setRaddr(0, 5'd7);
      applyStimulus(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b0, 5'd0);
      #1;
      checkOutput("dualByp", rd(0), 32'h22222222);
      tick();
      idleWrites();
      #1;
      checkOutput("dualArr", rd(0), 32'h22222222);

      re = 4'b0011;
      setRaddr(0, 5'd5); setRaddr(1, 5'd0);
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
      #1;
      checkOutput("bypR5", rd(0), 32'hDEADBEEF);
      checkOutput("bypR0", rd(1), 32'd0);
      tick();
      idleWrites();
      #1;
      checkOutput("arrR5", rd(0), 32'hDEADBEEF);
      checkOutput("arrR0", rd(1), 32'd0);

      re = 4'b0001;
      setRaddr(0, 5'd9); setRaddr(1, 5'd9);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
      #1;
      checkOutput("busyBefore", {28'b0, rbusy}, 32'd0);
      tick();
      idleWrites();
      #1;
      checkOutput("busySet", {28'b0, rbusy}, 32'b0001);
      applyStimulus(1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      #1;
      checkOutput("busyWbSame", {28'b0, rbusy}, 32'd0);
      checkOutput("busyWbData", rd(0), 32'h00000099);
      tick();
      idleWrites();
      #1;
      checkOutput("busyClr", {28'b0, rbusy}, 32'd0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h00000077, 1'b1, 5'd9);
      tick();
      idleWrites();
      #1;
      checkOutput("busySetWins", {28'b0, rbusy}, 32'b0001);
      checkOutput("busySetWinsData", rd(0), 32'h00000077);

      applyStimulus(1'b1, 5'd2, 32'h5A5A5A5A, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      idleWrites();
      re = 4'b1010;
      for (int p = 0; p < 4; p++) setRaddr(p, 5'd2);
      #1;
      checkOutput("rePort0", rd(0), 32'd0);
      checkOutput("rePort1", rd(1), 32'h5A5A5A5A);
      checkOutput("rePort2", rd(2), 32'd0);
      checkOutput("rePort3", rd(3), 32'h5A5A5A5A);

      // Mid-run reset wipes both the data and the scoreboard via the sweep.
      re = 4'b0001;
      setRaddr(0, 5'd4);
      applyStimulus(1'b1, 5'd4, 32'h00001234, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
      tick();
      idleWrites();
      #1;
      checkOutput("preRstData", rd(0), 32'h00001234);
      checkOutput("preRstBusy", {28'b0, rbusy}, 32'b0001);
      rst = 1'b1;
      tick();
      checkOutput("midRstReady", {31'b0, ready}, 32'd0);
      checkOutput("midRstBusy", {28'b0, rbusy}, 32'd0);
      checkOutput("midRstData", rd(0), 32'd0);
      rst = 1'b0;
      waitReady(1'b0, cycles);
      checkOutput("sweepLen2", cycles, 32'd31);
      checkOutput("postSweepR4", rd(0), 32'd0);
      checkOutput("postSweepBusy", {28'b0, rbusy}, 32'd0);

      // No-sweep instance: ready on first free edge, contents survive reset.
      ncRst = 1'b0;
      tick();
      checkOutput("ncReady", {31'b0, ncReady}, 32'd1);
      applyStimulus(1'b1, 5'd4, 32'h00001234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      idleWrites();
      ncRst = 1'b1;
      tick();
      checkOutput("ncRstReady2", {31'b0, ncReady}, 32'd0);
      checkOutput("ncRstRdata", ncRdata, 32'd0);
      ncRst = 1'b0;
      tick();
      checkOutput("ncReady2", {31'b0, ncReady}, 32'd1);
      checkOutput("ncKeep", ncRdata, 32'h00001234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
